// File: rtl/zx_timing_pkg.sv
// Shared timing definitions for the Spectrum clock-enable generator:
// CPU speed encodings, default divider/interrupt sizes and the divider-width helper.
package zx_timing_pkg;

    localparam int CE_BITS_DEF = 4;
    localparam int INT_LEN_DEF = 32;

    typedef enum logic [1:0] {
        SPEED_X1 = 2'd0,
        SPEED_X2 = 2'd1,
        SPEED_X4 = 2'd2,
        SPEED_X8 = 2'd3
    } speed_t;

    // Number of low counter bits that define one CPU period; never below 1 so the period stays >= 2 clocks.
    function automatic int cpu_k(input int ce_bits, input speed_t spd);
        int k;
        k = ce_bits - int'(spd);
        return (k < 1) ? 1 : k;
    endfunction

endpackage

// File: rtl/zx_int_stretch.sv
// Frame interrupt stretcher: synchronises the video interrupt, detects its falling
// edge and holds mi low for INT_LEN CPU cycles.
module zx_int_stretch
    import zx_timing_pkg::*;
#(
    parameter int INT_LEN = INT_LEN_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic cpu_en,
    input  logic vdu_int,
    output logic mi
);

    localparam int CNT_W = $clog2(INT_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(INT_LEN);

    logic [1:0]       sync_r;
    logic             last_r;
    logic [CNT_W-1:0] cnt_r;
    logic             mi_r;
    logic             fall_s;

    // Falling edge of the synchronised interrupt.
    always_comb begin
        fall_s = last_r & ~sync_r[1];
    end

    // Synchroniser, edge history and stretch counter; a new edge is ignored while a pulse is running.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_r <= 2'b11;
            last_r <= 1'b1;
            cnt_r  <= CNT_ZERO;
            mi_r   <= 1'b1;
        end else begin
            sync_r <= {sync_r[0], vdu_int};
            last_r <= sync_r[1];
            if (fall_s && (cnt_r == CNT_ZERO)) begin
                cnt_r <= CNT_LOAD;
                mi_r  <= 1'b0;
            end else if (cpu_en && (cnt_r != CNT_ZERO)) begin
                cnt_r <= cnt_r - CNT_ONE;
                if (cnt_r == CNT_ONE) begin
                    mi_r <= 1'b1;
                end
            end
        end
    end

    assign mi = mi_r;

endmodule

// File: rtl/zx_cegen.sv
// Clock-enable, contention and interrupt generator for the Spectrum core.
// Define ZX_CONTENTION_EN to compile in 48K-style memory/IO contention.
module zx_cegen
    import zx_timing_pkg::*;
#(
    parameter int CE_BITS = CE_BITS_DEF,
    parameter int INT_LEN = INT_LEN_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       locked,
    input  logic [1:0] speed,
    input  logic       vduCn,
    input  logic       vduI,
    input  logic       mreq,
    input  logic       ioFE,
    input  logic [1:0] ah,
    output logic       ce7M0p,
    output logic       ce7M0n,
    output logic       ce3M5p,
    output logic       ce3M5n,
    output logic       cep,
    output logic       cen,
    output logic       contend,
    output logic       mi
);

    localparam logic [CE_BITS-1:0] CE_ZERO   = {CE_BITS{1'b0}};
    localparam logic [CE_BITS-1:0] CE_ONE    = {{(CE_BITS-1){1'b0}}, 1'b1};
    localparam logic [CE_BITS-1:0] CE_ALL    = {CE_BITS{1'b1}};
    localparam logic [CE_BITS-1:0] PIX_MASK  = CE_ALL >> 1;
    localparam logic [CE_BITS-1:0] PIX_HALF  = CE_ONE << (CE_BITS - 2);
    localparam logic [CE_BITS-1:0] BASE_HALF = CE_ONE << (CE_BITS - 1);

    logic [CE_BITS-1:0] ce_r;
    logic               run_r;
    speed_t             speed_r;

    int                 k_s;
    logic [CE_BITS-1:0] cpu_mask_s;
    logic [CE_BITS-1:0] cpu_half_s;
    logic               gate_s;
    logic               pix_n_s;
    logic               pix_p_s;
    logic               base_n_s;
    logic               base_p_s;
    logic               cep_raw_s;
    logic               cen_raw_s;
    logic               cep_s;
    logic               cen_s;
    logic               contend_s;
    logic               mi_s;

    // Master divider; the speed request is only taken at the wrap so the new rate starts cleanly at zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ce_r    <= CE_ZERO;
            run_r   <= 1'b0;
            speed_r <= SPEED_X1;
        end else if (locked) begin
            ce_r  <= ce_r + CE_ONE;
            run_r <= 1'b1;
            if (ce_r == CE_ALL) begin
                speed_r <= speed_t'(speed);
            end
        end
    end

    // Enable decode from the divider state; everything is masked until the PLL is locked and running.
    always_comb begin
        k_s        = cpu_k(CE_BITS, speed_r);
        cpu_mask_s = (CE_ONE << k_s) - CE_ONE;
        cpu_half_s = CE_ONE << (k_s - 1);
        gate_s     = run_r & locked;
        pix_n_s    = gate_s && ((ce_r & PIX_MASK) == CE_ZERO);
        pix_p_s    = gate_s && ((ce_r & PIX_MASK) == PIX_HALF);
        base_n_s   = gate_s && (ce_r == CE_ZERO);
        base_p_s   = gate_s && (ce_r == BASE_HALF);
        cen_raw_s  = gate_s && ((ce_r & cpu_mask_s) == CE_ZERO);
        cep_raw_s  = gate_s && ((ce_r & cpu_mask_s) == cpu_half_s);
        cep_s      = cep_raw_s & contend_s;
        cen_s      = cen_raw_s & contend_s;
    end

`ifdef ZX_CONTENTION_EN
    logic mt_r;
    logic cpuck_r;

    // Bus-cycle type latched per CPU cycle, and the CPU-clock phase that stalls while contended.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mt_r    <= 1'b1;
            cpuck_r <= 1'b0;
        end else begin
            if (cep_s) begin
                mt_r <= mreq & ioFE;
            end
            if (pix_n_s) begin
                cpuck_r <= !(cpuck_r && contend_s);
            end
        end
    end

    // Contention only exists at base speed; turbo modes run uncontended.
    always_comb begin
        if (speed_r != SPEED_X1) begin
            contend_s = 1'b1;
        end else begin
            contend_s = !(vduCn && cpuck_r && mt_r && ((!ah[1] && ah[0]) || !ioFE));
        end
    end
`else
    logic unused_s;

    // Without contention the CPU clock is never stretched.
    always_comb begin
        contend_s = 1'b1;
        unused_s  = ^{vduCn, mreq, ioFE, ah};
    end
`endif

    zx_int_stretch #(
        .INT_LEN (INT_LEN)
    ) u_int_stretch (
        .clock   (clock),
        .reset   (reset),
        .cpu_en  (cep_s),
        .vdu_int (vduI),
        .mi      (mi_s)
    );

    // Output drive.
    always_comb begin
        ce7M0n  = pix_n_s;
        ce7M0p  = pix_p_s;
        ce3M5n  = base_n_s;
        ce3M5p  = base_p_s;
        cep     = cep_s;
        cen     = cen_s;
        contend = contend_s;
        mi      = mi_s;
    end

endmodule

// File: tb/tb_zx_cegen.sv
// Directed self-checking bench for zx_cegen: enable rates, speed switch, lock loss,
// interrupt stretch, contention and asynchronous reset.
module tb_zx_cegen;

    localparam int CE_BITS = 4;
    localparam int INT_LEN = 32;

    logic       clock  = 1'b0;
    logic       reset  = 1'b0;
    logic       locked = 1'b1;
    logic [1:0] speed  = 2'd0;
    logic       vduCn  = 1'b0;
    logic       vduI   = 1'b1;
    logic       mreq   = 1'b1;
    logic       ioFE   = 1'b1;
    logic [1:0] ah     = 2'b00;
    logic       ce7M0p, ce7M0n, ce3M5p, ce3M5n, cep, cen, contend, mi;

    int checks   = 0;
    int failures = 0;

    int ce_m    = 0;
    int spd_m   = 0;
    bit run_m   = 1'b0;
    bit vec_chk = 1'b0;

    logic [5:0] obs;
    assign obs = {ce7M0p, ce7M0n, ce3M5p, ce3M5n, cep, cen};

    zx_cegen #(
        .CE_BITS (CE_BITS),
        .INT_LEN (INT_LEN)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .locked  (locked),
        .speed   (speed),
        .vduCn   (vduCn),
        .vduI    (vduI),
        .mreq    (mreq),
        .ioFE    (ioFE),
        .ah      (ah),
        .ce7M0p  (ce7M0p),
        .ce7M0n  (ce7M0n),
        .ce3M5p  (ce3M5p),
        .ce3M5n  (ce3M5n),
        .cep     (cep),
        .cen     (cen),
        .contend (contend),
        .mi      (mi)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h ce=%0d t=%0t", tag, got, exp, ce_m, $time);
        end
    endtask

    // Expected {7M0p,7M0n,3M5p,3M5n,cep,cen} for counter value c at speed s.
    function automatic logic [5:0] exp_vec(input int c, input int s);
        int k;
        int per;
        k = CE_BITS - s;
        if (k < 1) k = 1;
        per = 1 << k;
        return {(c % 8) == 4, (c % 8) == 0, c == 8, c == 0,
                (c % per) == (per / 2), (c % per) == 0};
    endfunction

    task automatic cycle(input string tag);
        @(posedge clock);
        if (reset && locked) begin
            if (ce_m == 15) spd_m = int'(speed);
            ce_m  = (ce_m + 1) % 16;
            run_m = 1'b1;
        end
        @(negedge clock);
        if (vec_chk) begin
            check(tag, {26'd0, obs}, (run_m && locked) ? {26'd0, exp_vec(ce_m, spd_m)} : 32'd0);
        end
    endtask

    task automatic wait_ce(input int target);
        for (int i = 0; i < 40 && ce_m != target; i++) cycle("wait");
    endtask

    task automatic count_window(output int n_cep, output int n_cen, output int n_hi);
        n_cep = 0;
        n_cen = 0;
        n_hi  = 0;
        for (int i = 0; i < 32; i++) begin
            cycle("window");
            if (cep) n_cep++;
            if (cen) n_cen++;
            if (contend) n_hi++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        int ceps;
        int low_after;
        int n_cep, n_cen, n_hi;
        bit rose;

        // Reset held: no enables, idle interrupt and contention.
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("rst_en", {26'd0, obs}, 32'd0);
        end
        check("rst_mi", {31'd0, mi}, 32'd1);
        check("rst_contend", {31'd0, contend}, 32'd1);

        // Base rates.
        reset   = 1'b1;
        vec_chk = 1'b1;
        repeat (48) cycle("base");

        // Lock loss mid-period.
        wait_ce(5);
        locked = 1'b0;
        repeat (20) cycle("lock_off");
        locked = 1'b1;
        repeat (40) cycle("lock_resume");

        // Speed 0 -> 3 requested at ce=5.
        wait_ce(5);
        speed = 2'd3;
        repeat (48) cycle("speed_x8");

        // Interrupt at x4.
        wait_ce(5);
        speed = 2'd2;
        repeat (16) cycle("to_x4");
        vduI = 1'b0;
        cycle("int_a");
        check("int_lat1", {31'd0, mi}, 32'd1);
        cycle("int_b");
        check("int_lat2", {31'd0, mi}, 32'd1);
        cycle("int_c");
        check("int_lat3", {31'd0, mi}, 32'd0);
        ceps = 0;
        rose = 1'b0;
        for (int t = 3; t < 400 && !rose; t++) begin
            if (mi == 1'b1) begin
                rose = 1'b1;
            end else begin
                if (cep) ceps++;
                vduI = !((t < 56) || (t >= 90 && t < 100));
                cycle("int_run");
            end
        end
        vduI = 1'b1;
        check("int_rise", {31'd0, rose}, 32'd1);
        check("int_len", ceps, INT_LEN);
        low_after = 0;
        for (int i = 0; i < 64; i++) begin
            cycle("int_after");
            if (!mi) low_after++;
        end
        check("int_no_retrig", low_after, 32'd0);

        // Contention at base speed.
        vec_chk = 1'b0;
        speed   = 2'd0;
        repeat (32) cycle("to_x1");
        wait_ce(1);
        vduCn = 1'b1;
        ah    = 2'b01;
        repeat (32) cycle("cont_settle");
        count_window(n_cep, n_cen, n_hi);
`ifdef ZX_CONTENTION_EN
        check("cont_cep", n_cep, 32'd0);
        check("cont_cen", n_cen, 32'd0);
        check("cont_low", n_hi, 32'd0);
`else
        check("cont_cep", n_cep, 32'd2);
        check("cont_cen", n_cen, 32'd2);
        check("cont_low", n_hi, 32'd32);
`endif
        vduCn = 1'b0;
        #1;
        check("cont_release", {31'd0, contend}, 32'd1);
        count_window(n_cep, n_cen, n_hi);
        check("cont_rel_cep", n_cep, 32'd2);

        // Upper-memory access is never contended.
        vduCn = 1'b1;
        ah    = 2'b10;
        count_window(n_cep, n_cen, n_hi);
        check("cont_ah10_cep", n_cep, 32'd2);
        check("cont_ah10_hi", n_hi, 32'd32);

        // Same stimulus at x2: no suppression.
        vduCn = 1'b0;
        speed = 2'd1;
        repeat (32) cycle("to_x2");
        vduCn = 1'b1;
        ah    = 2'b01;
        count_window(n_cep, n_cen, n_hi);
        check("turbo_cep", n_cep, 32'd4);
        check("turbo_cen", n_cen, 32'd4);
        check("turbo_hi", n_hi, 32'd32);
        vduCn = 1'b0;
        ah    = 2'b00;

        // Asynchronous reset in the middle of an interrupt pulse, on a cep cycle.
        vec_chk = 1'b1;
        vduI = 1'b0;
        repeat (3) cycle("rst_int");
        vduI = 1'b1;
        check("rst_pre_mi", {31'd0, mi}, 32'd0);
        for (int i = 0; i < 16 && (ce_m % 8) != 4; i++) cycle("rst_wait");
        check("rst_pre_cep", {31'd0, cep}, 32'd1);
        vec_chk = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        check("rst_async_en", {26'd0, obs}, 32'd0);
        check("rst_async_mi", {31'd0, mi}, 32'd1);
        check("rst_async_contend", {31'd0, contend}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
